// File: rtl/dec_pkg.sv
// rtl/dec_pkg.sv - shared state type, mode constants and Gray helper for decoder_n_scan
package dec_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIRECT = 2'd1,
      SCAN   = 2'd2
   } dec_state_t;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   // Widest select the decoder is built for; narrower selects are zero-extended.
   localparam int MAX_SEL_W = 6;

   function automatic logic [MAX_SEL_W-1:0] bin2gray(input logic [MAX_SEL_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

endpackage

// File: rtl/dec_onehot.sv
// rtl/dec_onehot.sv - combinational SEL_W-to-2**SEL_W binary-to-one-hot decoder with enable
module dec_onehot #(
   parameter int SEL_W = 3
) (
   input  logic                    en,
   input  logic [SEL_W-1:0]        sel,
   output logic [(2**SEL_W)-1:0]   y
);

   localparam int OUT_W = 2**SEL_W;

   assign y = en ? (OUT_W'(1) << sel) : '0;

endmodule

// File: rtl/decoder_n_scan.sv
// rtl/decoder_n_scan.sv - registered one-hot decoder with DIRECT/SCAN modes; DEC_GRAY_SCAN_EN selects Gray scan order
module decoder_n_scan
   import dec_pkg::*;
#(
   parameter int SEL_W = 3,
   parameter int DWELL = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    mode,
   input  logic                    sel_valid,
   input  logic [SEL_W-1:0]        sel,
   output logic                    sel_ready,
   output logic [(2**SEL_W)-1:0]   q,
   output logic [SEL_W-1:0]        idx,
   output logic                    wrap
);

   localparam int OUT_W = 2**SEL_W;
   localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL - 1);

   dec_state_t        state, state_nxt;
   logic [SEL_W-1:0]  cnt, cnt_nxt, cnt_inc;
   logic [DW_W-1:0]   dwell, dwell_nxt;
   logic [SEL_W-1:0]  idx_nxt;
   logic              wrap_nxt;
   logic              load_q;
   logic [OUT_W-1:0]  dec_q;

   function automatic logic [SEL_W-1:0] scan_order(input logic [SEL_W-1:0] c);
`ifdef DEC_GRAY_SCAN_EN
      logic [MAX_SEL_W-1:0] g;
      g = bin2gray(MAX_SEL_W'(c));
      return g[SEL_W-1:0];
`else
      return c;
`endif
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = IDLE;
      if (en) begin
         state_nxt = (mode == MODE_SCAN) ? SCAN : DIRECT;
      end
   end

   assign cnt_inc = cnt + SEL_W'(1);

   // Everything below is decided by the state being entered, so a mode or enable
   // change discards any partial dwell on the very next edge.
   always_comb begin
      sel_ready = (state == DIRECT);
      load_q    = 1'b0;
      idx_nxt   = idx;
      wrap_nxt  = 1'b0;
      cnt_nxt   = '0;
      dwell_nxt = '0;
      unique case (state_nxt)
         IDLE: begin
            load_q = 1'b1;
         end
         DIRECT: begin
            if (sel_valid && sel_ready) begin
               load_q  = 1'b1;
               idx_nxt = sel;
            end
         end
         SCAN: begin
            if (state != SCAN) begin
               load_q  = 1'b1;
               idx_nxt = scan_order('0);
            end else if (dwell == DW_LAST) begin
               load_q   = 1'b1;
               cnt_nxt  = cnt_inc;
               idx_nxt  = scan_order(cnt_inc);
               wrap_nxt = (cnt == {SEL_W{1'b1}});
            end else begin
               cnt_nxt   = cnt;
               dwell_nxt = dwell + DW_W'(1);
            end
         end
         default: begin
            load_q = 1'b1;
         end
      endcase
   end

   // Disabled decoder yields all-zero, which is what IDLE loads into q.
   dec_onehot #(
      .SEL_W (SEL_W)
   ) u_onehot (
      .en  (state_nxt != IDLE),
      .sel (idx_nxt),
      .y   (dec_q)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q     <= '0;
         idx   <= '0;
         wrap  <= 1'b0;
         cnt   <= '0;
         dwell <= '0;
      end else begin
         if (load_q) begin
            q   <= dec_q;
            idx <= idx_nxt;
         end
         wrap  <= wrap_nxt;
         cnt   <= cnt_nxt;
         dwell <= dwell_nxt;
      end
   end

endmodule
